// File: rtl/sonar_sweep_sequencer_if.sv
// Result record channel of the sonar sweep sequencer: valid/ready handshake plus the
// angle, hit flag, time of flight and peak level reported once per ping.

interface sonar_sweep_sequencer_if #(
   parameter int SAMPLE_WIDTH = 16,
   parameter int ANGLE_WIDTH  = 8,
   parameter int TIME_WIDTH   = 24
);
   logic                           result_valid_out;
   logic                           result_ready_in;
   logic signed [ANGLE_WIDTH-1:0]  result_angle_out;
   logic                           result_hit_out;
   logic [TIME_WIDTH-1:0]          result_tof_out;
   logic [SAMPLE_WIDTH-1:0]        result_peak_out;

   modport master (
      output result_valid_out,
      output result_angle_out,
      output result_hit_out,
      output result_tof_out,
      output result_peak_out,
      input  result_ready_in
   );

   modport slave (
      input  result_valid_out,
      input  result_angle_out,
      input  result_hit_out,
      input  result_tof_out,
      input  result_peak_out,
      output result_ready_in
   );
endinterface

// File: rtl/sonar_sweep_sequencer.sv
// Ping/sweep sequencer: transmit burst, listen with ADC triggers and echo scan, then one
// result record per beam angle. Define SONAR_SWEEP_BOUNCE_EN for a ping-pong sweep.

module sonar_sweep_sequencer #(
   parameter int PERIOD_CYCLES      = 16777216,
   parameter int BURST_CYCLES       = 524288,
   parameter int CYCLES_PER_TRIGGER = 100,
   parameter int SAMPLE_WIDTH       = 16,
   parameter int ANGLE_WIDTH        = 8,
   parameter int ANGLE_MIN          = -30,
   parameter int ANGLE_MAX          = 30,
   parameter int ANGLE_STEP         = 10,
   parameter int TIME_WIDTH         = $clog2(PERIOD_CYCLES)
) (
   input  logic                          clk_in,
   input  logic                          rst_in,
   input  logic                          enable_in,
   input  logic [SAMPLE_WIDTH-1:0]       threshold_in,
   input  logic [SAMPLE_WIDTH-1:0]       sample_in,
   input  logic                          sample_valid_in,
   output logic signed [ANGLE_WIDTH-1:0] beam_angle_out,
   output logic                          burst_out,
   output logic                          ping_start_out,
   output logic                          sample_trigger_out,
   output logic [TIME_WIDTH-1:0]         time_since_emission_out,
   sonar_sweep_sequencer_if.master       result_if
);

   localparam logic [TIME_WIDTH-1:0]         BURST_LAST  = TIME_WIDTH'(BURST_CYCLES - 1);
   localparam logic [TIME_WIDTH-1:0]         PERIOD_LAST = TIME_WIDTH'(PERIOD_CYCLES - 1);
   localparam int                            TRIG_WIDTH  = (CYCLES_PER_TRIGGER > 1) ? $clog2(CYCLES_PER_TRIGGER) : 1;
   localparam logic [TRIG_WIDTH-1:0]         TRIG_LAST   = TRIG_WIDTH'(CYCLES_PER_TRIGGER - 1);
   localparam logic signed [ANGLE_WIDTH:0]   MIN_EXT     = (ANGLE_WIDTH + 1)'(ANGLE_MIN);
   localparam logic signed [ANGLE_WIDTH:0]   MAX_EXT     = (ANGLE_WIDTH + 1)'(ANGLE_MAX);
   localparam logic signed [ANGLE_WIDTH:0]   STEP_EXT    = (ANGLE_WIDTH + 1)'(ANGLE_STEP);
   localparam logic signed [ANGLE_WIDTH-1:0] ANGLE_START = ANGLE_WIDTH'(ANGLE_MIN);

   typedef enum logic [2:0] {IDLE, BURST, LISTEN, REPORT, STEP} state_t;

   state_t                        state_q, state_d;
   logic                          entering_burst, entering_listen, leaving_listen, handshake;
   logic [TRIG_WIDTH-1:0]         trig_cnt, trig_next;
   logic                          hit_q, hit_d;
   logic [TIME_WIDTH-1:0]         tof_q, tof_d;
   logic [SAMPLE_WIDTH-1:0]       peak_q, peak_d;
   logic signed [ANGLE_WIDTH:0]   angle_ext, sum_up;
   logic signed [ANGLE_WIDTH-1:0] angle_d;
`ifdef SONAR_SWEEP_BOUNCE_EN
   logic                          dir_up_q, dir_up_d;
   logic signed [ANGLE_WIDTH:0]   sum_dn;
`endif

   // Phase transitions; the shared time counter marks the end of burst and of listen.
   always_comb begin
      state_d   = state_q;
      handshake = result_if.result_valid_out && result_if.result_ready_in;
      case (state_q)
         IDLE:    if (enable_in) state_d = BURST;
         BURST:   if (time_since_emission_out == BURST_LAST) state_d = LISTEN;
         LISTEN:  if (time_since_emission_out == PERIOD_LAST) state_d = REPORT;
         REPORT:  if (handshake) state_d = STEP;
         STEP:    state_d = enable_in ? BURST : IDLE;
         default: state_d = IDLE;
      endcase
      entering_burst  = (state_d == BURST) && (state_q != BURST);
      entering_listen = (state_d == LISTEN) && (state_q != LISTEN);
      leaving_listen  = (state_q == LISTEN) && (state_d == REPORT);
      trig_next       = (trig_cnt == TRIG_LAST) ? '0 : trig_cnt + TRIG_WIDTH'(1);
   end

   // Echo scan includes the current sample so the last listen cycle reaches the result.
   always_comb begin
      hit_d  = hit_q;
      tof_d  = tof_q;
      peak_d = peak_q;
      if ((state_q == LISTEN) && sample_valid_in) begin
         if ((sample_in > threshold_in) && !hit_q) begin
            hit_d = 1'b1;
            tof_d = time_since_emission_out;
         end
         if (sample_in > peak_q) peak_d = sample_in;
      end
   end

   // Next beam angle, one bit wider so the limit comparison cannot overflow.
   always_comb begin
      angle_ext = {beam_angle_out[ANGLE_WIDTH-1], beam_angle_out};
      sum_up    = angle_ext + STEP_EXT;
      angle_d   = sum_up[ANGLE_WIDTH-1:0];
`ifdef SONAR_SWEEP_BOUNCE_EN
      sum_dn   = angle_ext - STEP_EXT;
      dir_up_d = dir_up_q;
      if (dir_up_q) begin
         if (sum_up > MAX_EXT) begin
            dir_up_d = 1'b0;
            angle_d  = sum_dn[ANGLE_WIDTH-1:0];
         end
      end else if (sum_dn < MIN_EXT) begin
         dir_up_d = 1'b1;
      end else begin
         angle_d = sum_dn[ANGLE_WIDTH-1:0];
      end
`else
      if (sum_up > MAX_EXT) angle_d = ANGLE_START;
`endif
   end

   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         state_q                 <= IDLE;
         burst_out               <= 1'b0;
         ping_start_out          <= 1'b0;
         sample_trigger_out      <= 1'b0;
         time_since_emission_out <= '0;
         trig_cnt                <= '0;
      end else begin
         state_q        <= state_d;
         burst_out      <= (state_d == BURST);
         ping_start_out <= entering_burst;
         if (entering_burst)
            time_since_emission_out <= '0;
         else if ((state_d == BURST) || (state_d == LISTEN))
            time_since_emission_out <= time_since_emission_out + TIME_WIDTH'(1);
         if (entering_listen) begin
            trig_cnt           <= '0;
            sample_trigger_out <= 1'b1;
         end else if ((state_q == LISTEN) && (state_d == LISTEN)) begin
            trig_cnt           <= trig_next;
            sample_trigger_out <= (trig_next == '0);
         end else begin
            sample_trigger_out <= 1'b0;
         end
      end
   end

   // Scan accumulators restart with every ping; results stay stable until accepted.
   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         hit_q                      <= 1'b0;
         tof_q                      <= '0;
         peak_q                     <= '0;
         result_if.result_valid_out <= 1'b0;
         result_if.result_angle_out <= '0;
         result_if.result_hit_out   <= 1'b0;
         result_if.result_tof_out   <= '0;
         result_if.result_peak_out  <= '0;
      end else begin
         if (entering_burst) begin
            hit_q  <= 1'b0;
            tof_q  <= '0;
            peak_q <= '0;
         end else begin
            hit_q  <= hit_d;
            tof_q  <= tof_d;
            peak_q <= peak_d;
         end
         if (leaving_listen) begin
            result_if.result_valid_out <= 1'b1;
            result_if.result_angle_out <= beam_angle_out;
            result_if.result_hit_out   <= hit_d;
            result_if.result_tof_out   <= tof_d;
            result_if.result_peak_out  <= peak_d;
         end else if (handshake) begin
            result_if.result_valid_out <= 1'b0;
         end
      end
   end

   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         beam_angle_out <= ANGLE_START;
`ifdef SONAR_SWEEP_BOUNCE_EN
         dir_up_q       <= 1'b1;
`endif
      end else if (state_q == STEP) begin
         beam_angle_out <= angle_d;
`ifdef SONAR_SWEEP_BOUNCE_EN
         dir_up_q       <= dir_up_d;
`endif
      end
   end

endmodule

// File: tb/tb_sonar_sweep_sequencer.sv
// Directed bench for sonar_sweep_sequencer with a short 64-cycle ping; expected angles
// follow SONAR_SWEEP_BOUNCE_EN when it is defined.

module tb_sonar_sweep_sequencer;

   localparam int SW = 16;
   localparam int AW = 8;
   localparam int TW = 6;

   logic                 clk_100mhz = 1'b0;
   logic                 rst = 1'b0;
   logic                 enable = 1'b0;
   logic [SW-1:0]        threshold = 16'd5000;
   logic [SW-1:0]        sample = '0;
   logic                 sample_valid = 1'b0;
   logic signed [AW-1:0] beam_angle;
   logic                 burst, ping_start, sample_trigger;
   logic [TW-1:0]        time_out;

   int cyc = 0;
   int vectors = 0;
   int miscompares = 0;

   int   plan_n = 0;
   int   plan_t[4];
   int   plan_s[4];
   logic plan_b[4];
   logic plan_q[4];

`ifdef SONAR_SWEEP_BOUNCE_EN
   int exp_sweep[10] = '{10, 20, 30, 20, 10, 0, -10, -20, -30, -20};
`else
   int exp_sweep[10] = '{10, 20, 30, -30, -20, -10, 0, 10, 20, 30};
`endif

   sonar_sweep_sequencer_if #(.SAMPLE_WIDTH(SW), .ANGLE_WIDTH(AW), .TIME_WIDTH(TW)) res_if ();

   sonar_sweep_sequencer #(
      .PERIOD_CYCLES(64), .BURST_CYCLES(8), .CYCLES_PER_TRIGGER(4),
      .SAMPLE_WIDTH(SW), .ANGLE_WIDTH(AW), .ANGLE_MIN(-30), .ANGLE_MAX(30),
      .ANGLE_STEP(10), .TIME_WIDTH(TW)
   ) dut (
      .clk_in(clk_100mhz), .rst_in(rst), .enable_in(enable),
      .threshold_in(threshold), .sample_in(sample), .sample_valid_in(sample_valid),
      .beam_angle_out(beam_angle), .burst_out(burst), .ping_start_out(ping_start),
      .sample_trigger_out(sample_trigger), .time_since_emission_out(time_out),
      .result_if(res_if.master)
   );

   always #5 clk_100mhz = ~clk_100mhz;
   always @(posedge clk_100mhz) cyc <= cyc + 1;

   task automatic checkOutput(input string tag, input logic signed [31:0] observed,
                              input logic signed [31:0] expected);
      vectors++;
      if (observed !== expected) begin
         miscompares++;
         $display("[TB] FAIL %s: observed %0d, expected %0d", tag, observed, expected);
      end
   endtask

   task automatic addEcho(input int t, input logic in_burst, input int s, input logic q);
      plan_t[plan_n] = t;
      plan_b[plan_n] = in_burst;
      plan_s[plan_n] = s;
      plan_q[plan_n] = q;
      plan_n++;
   endtask

   // Presents the planned sample for the cycle the DUT is currently in.
   task automatic applyStimulus();
      sample       = '0;
      sample_valid = 1'b0;
      for (int i = 0; i < plan_n; i++)
         if ((int'(time_out) == plan_t[i]) && (burst == plan_b[i])) begin
            sample       = SW'(plan_s[i]);
            sample_valid = plan_q[i];
         end
   endtask

   task automatic tick();
      @(negedge clk_100mhz);
      applyStimulus();
   endtask

   task automatic waitPingStart(output int waited);
      waited = 0;
      do begin
         tick();
         waited++;
      end while (!ping_start && waited < 300);
      if (!ping_start) checkOutput("ping_start_timeout", 0, 1);
   endtask

   task automatic waitValid();
      for (int k = 0; k < 200 && !res_if.result_valid_out; k++) tick();
      if (!res_if.result_valid_out) checkOutput("result_valid_timeout", 0, 1);
   endtask

   // Called on the ping_start cycle; returns on the cycle result_valid rises.
   task automatic measurePing(output int burst_n, output int trig_n, output int spacing_err,
                              output int first_trig_t, output int valid_lat);
      int start_cyc, last_trig;
      start_cyc = cyc;
      last_trig = 0;
      burst_n = 0; trig_n = 0; spacing_err = 0; first_trig_t = -1;
      for (int k = 0; k < 200 && !res_if.result_valid_out; k++) begin
         if (burst) burst_n++;
         if (sample_trigger) begin
            if (trig_n == 0) first_trig_t = int'(time_out);
            else if (cyc - last_trig != 4) spacing_err++;
            last_trig = cyc;
            trig_n++;
         end
         tick();
      end
      valid_lat = cyc - start_cyc;
      if (!res_if.result_valid_out) checkOutput("result_valid_timeout", 0, 1);
   endtask

   initial begin
      int waited, burst_n, trig_n, spacing_err, first_trig_t, valid_lat;
      int start_cyc, stall_err, stray;

      res_if.result_ready_in = 1'b1;
      #2 rst = 1'b1;
      tick();
      tick();
      checkOutput("reset_angle", beam_angle, -30);
      checkOutput("reset_burst", burst, 0);
      checkOutput("reset_ping_start", ping_start, 0);
      checkOutput("reset_trigger", sample_trigger, 0);
      checkOutput("reset_time", time_out, 0);
      checkOutput("reset_valid", res_if.result_valid_out, 0);
      checkOutput("reset_result_peak", res_if.result_peak_out, 0);
      rst = 1'b0;
      tick();
      checkOutput("idle_no_burst", burst, 0);

      // Ping 1: crossing at t=30, burst-time sample ignored.
      addEcho(3, 1'b1, 7000, 1'b1);
      addEcho(20, 1'b0, 4000, 1'b1);
      addEcho(30, 1'b0, 6000, 1'b1);
      addEcho(40, 1'b0, 9000, 1'b1);
      enable = 1'b1;
      waitPingStart(waited);
      checkOutput("enable_to_ping_start", waited, 1);
      checkOutput("ping1_burst_at_start", burst, 1);
      checkOutput("ping1_time_at_start", time_out, 0);
      checkOutput("ping1_angle", beam_angle, -30);
      start_cyc = cyc;
      measurePing(burst_n, trig_n, spacing_err, first_trig_t, valid_lat);
      checkOutput("burst_cycles", burst_n, 8);
      checkOutput("trigger_count", trig_n, 14);
      checkOutput("trigger_spacing_errors", spacing_err, 0);
      checkOutput("first_trigger_time", first_trig_t, 8);
      checkOutput("valid_latency", valid_lat, 64);
      checkOutput("time_held_in_report", time_out, 63);
      checkOutput("ping1_result_angle", res_if.result_angle_out, -30);
      checkOutput("ping1_hit", res_if.result_hit_out, 1);
      checkOutput("ping1_tof", res_if.result_tof_out, 30);
      checkOutput("ping1_peak", res_if.result_peak_out, 9000);

      // Ping 2: nothing strictly above threshold; large burst sample still ignored.
      waitPingStart(waited);
      checkOutput("ping_spacing", cyc - start_cyc, 66);
      checkOutput("ping2_angle", beam_angle, -20);
      plan_n = 0;
      addEcho(3, 1'b1, 7000, 1'b1);
      addEcho(10, 1'b0, 4999, 1'b1);
      addEcho(50, 1'b0, 3000, 1'b1);
      waitValid();
      checkOutput("ping2_hit", res_if.result_hit_out, 0);
      checkOutput("ping2_tof", res_if.result_tof_out, 0);
      checkOutput("ping2_peak", res_if.result_peak_out, 4999);

      // Ping 3: consumer stalls for 20 cycles; unqualified samples are ignored.
      waitPingStart(waited);
      checkOutput("ping3_angle", beam_angle, -10);
      plan_n = 0;
      addEcho(25, 1'b0, 8000, 1'b0);
      addEcho(30, 1'b0, 100, 1'b1);
      res_if.result_ready_in = 1'b0;
      waitValid();
      stall_err = 0;
      for (int k = 0; k < 20; k++) begin
         tick();
         if (res_if.result_valid_out !== 1'b1 || res_if.result_angle_out !== -8'sd10 ||
             res_if.result_hit_out !== 1'b0 || res_if.result_tof_out !== '0 ||
             res_if.result_peak_out !== 16'd100 || ping_start !== 1'b0 || burst !== 1'b0)
            stall_err++;
      end
      checkOutput("stall_violations", stall_err, 0);
      checkOutput("ping3_peak", res_if.result_peak_out, 100);
      res_if.result_ready_in = 1'b1;
      tick();
      checkOutput("valid_drops_after_accept", res_if.result_valid_out, 0);
      tick();
      checkOutput("ping_start_2_after_accept", ping_start, 1);

      // Ping 4: enable falls mid-listen; the ping still reports, then the sweep parks.
      checkOutput("ping4_angle", beam_angle, 0);
      plan_n = 0;
      addEcho(60, 1'b0, 6000, 1'b1);
      for (int k = 0; k < 100 && !(int'(time_out) == 30 && !burst); k++) tick();
      enable = 1'b0;
      waitValid();
      checkOutput("ping4_result_angle", res_if.result_angle_out, 0);
      checkOutput("ping4_hit", res_if.result_hit_out, 1);
      checkOutput("ping4_tof", res_if.result_tof_out, 60);
      checkOutput("ping4_peak", res_if.result_peak_out, 6000);
      tick();
      tick();
      checkOutput("angle_after_disable", beam_angle, 10);
      stray = 0;
      for (int k = 0; k < 150; k++) begin
         tick();
         if (burst || ping_start || res_if.result_valid_out) stray++;
      end
      checkOutput("idle_activity_after_disable", stray, 0);

      // Continuous sweep across both limits.
      plan_n = 0;
      enable = 1'b1;
      for (int i = 0; i < 10; i++) begin
         waitPingStart(waited);
         checkOutput($sformatf("sweep_angle_%0d", i), beam_angle, exp_sweep[i]);
         waitValid();
         checkOutput($sformatf("sweep_result_angle_%0d", i), res_if.result_angle_out, exp_sweep[i]);
      end

      // Asynchronous reset in the middle of a burst.
      waitPingStart(waited);
      tick();
      tick();
      tick();
      checkOutput("pre_reset_in_burst", burst, 1);
      rst = 1'b1;
      #1;
      checkOutput("async_reset_burst", burst, 0);
      checkOutput("async_reset_angle", beam_angle, -30);
      checkOutput("async_reset_time", time_out, 0);
      checkOutput("async_reset_valid", res_if.result_valid_out, 0);
      enable = 1'b0;
      tick();
      tick();
      rst = 1'b0;
      stray = 0;
      for (int k = 0; k < 100; k++) begin
         tick();
         if (burst || res_if.result_valid_out) stray++;
      end
      checkOutput("no_result_after_reset", stray, 0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
